// File: rtl/cpu7_exu_excp_ctl_if.sv
// Redirect handshake between the _e exception arbiter (master) and the IFU (slave).
// redirect_vld/redirect_pc are held stable until the cycle ifu_redirect_ack is high.
interface cpu7_exu_excp_ctl_if #(
   parameter int GRLEN = 32
);
   logic             redirect_vld;
   logic [GRLEN-1:0] redirect_pc;
   logic             ifu_redirect_ack;

   modport master (
      output redirect_vld,
      output redirect_pc,
      input  ifu_redirect_ack
   );

   modport slave (
      input  redirect_vld,
      input  redirect_pc,
      output ifu_redirect_ack
   );
endinterface

// File: rtl/cpu7_exu_excp_ctl.sv
// _e stage exception/ERTN arbiter: pulses one CSR control per event, holds a redirect
// to the IFU until acked, then squashes _e for DRAIN_CYC cycles while the new stream arrives.
module cpu7_exu_excp_ctl #(
   parameter int GRLEN     = 32,
   parameter int DRAIN_CYC = 2,
   parameter int ECODE_W   = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_e,
   input  logic [GRLEN-1:0]    pc_e,
   input  logic                ale_e,
   input  logic [GRLEN-1:0]    badv_e,
   input  logic                illinst_e,
   input  logic                ertn_e,
   input  logic                timer_intr,
   input  logic [GRLEN-1:0]    csr_eentry,
   input  logic [GRLEN-1:0]    csr_era,
   output logic                exu_ifu_except,
   output logic                ecl_csr_ale_e,
   output logic                ecl_csr_illinst_e,
   output logic                ecl_csr_ertn_e,
   output logic [GRLEN-1:0]    lsu_csr_badv_e,
   output logic                kill_e,
   output logic [ECODE_W-1:0]  ecode,
   output logic [1:0]          dbg_state,
   cpu7_exu_excp_ctl_if.master redir
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REDIR = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [2:0]         L_DRAIN_INIT = 3'(DRAIN_CYC - 1);
   localparam logic [ECODE_W-1:0] L_ECODE_INT  = ECODE_W'('h00);
   localparam logic [ECODE_W-1:0] L_ECODE_INE  = ECODE_W'('h0D);
   localparam logic [ECODE_W-1:0] L_ECODE_ALE  = ECODE_W'('h09);

   state_t             r_state, w_state_nxt;
   logic [2:0]         r_cnt, w_cnt_nxt;
   logic [GRLEN-1:0]   r_redirect_pc, w_redirect_pc_nxt;
   logic [ECODE_W-1:0] r_ecode, w_ecode_nxt;
   logic               w_idle, w_ev, w_rt;
   logic               w_unused;

   // ERA for the redirect comes from the CSR block, so pc_e has no consumer here.
   assign w_unused = ^pc_e;

   always_comb begin
      // In the reset cycle the combinational side behaves as if already IDLE.
      w_idle = (r_state == S_IDLE) | rst;
      w_ev   = w_idle & valid_e & (timer_intr | illinst_e | ale_e);
      w_rt   = w_idle & valid_e & ertn_e & ~w_ev;

      exu_ifu_except    = w_ev;
      ecl_csr_illinst_e = w_ev & ~timer_intr & illinst_e;
      ecl_csr_ale_e     = w_ev & ~timer_intr & ~illinst_e & ale_e;
      ecl_csr_ertn_e    = w_rt;
      kill_e            = w_ev | ~w_idle;
      lsu_csr_badv_e    = badv_e;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_redirect_pc_nxt = r_redirect_pc;
      w_ecode_nxt       = r_ecode;
      case (r_state)
         S_IDLE: begin
            if (w_ev | w_rt) begin
               w_state_nxt       = S_REDIR;
               w_redirect_pc_nxt = w_ev ? csr_eentry : csr_era;
            end
            if (w_ev) begin
               if (timer_intr)     w_ecode_nxt = L_ECODE_INT;
               else if (illinst_e) w_ecode_nxt = L_ECODE_INE;
               else                w_ecode_nxt = L_ECODE_ALE;
            end
         end
         S_REDIR: begin
            if (redir.ifu_redirect_ack) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = L_DRAIN_INIT;
            end
         end
         S_DRAIN: begin
            if (r_cnt == 3'd0) w_state_nxt = S_IDLE;
            else               w_cnt_nxt   = r_cnt - 3'd1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= 3'd0;
         r_redirect_pc <= '0;
         r_ecode       <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_redirect_pc <= w_redirect_pc_nxt;
         r_ecode       <= w_ecode_nxt;
      end
   end

   assign redir.redirect_vld = (r_state == S_REDIR);
   assign redir.redirect_pc  = r_redirect_pc;
   assign ecode              = r_ecode;
   assign dbg_state          = r_state;

endmodule

// File: tb/tb_cpu7_exu_excp_ctl.sv
// Randomized bench for cpu7_exu_excp_ctl with a timeline reference model and
// an expected-response queue checked every cycle by an independent monitor.
module tb_cpu7_exu_excp_ctl;

   localparam int GRLEN     = 32;
   localparam int DRAIN_CYC = 2;
   localparam int ECODE_W   = 6;
   localparam int W         = 6 + GRLEN + GRLEN + ECODE_W;

   typedef struct packed {
      logic        rst;
      logic        valid;
      logic        ale;
      logic        ill;
      logic        ertn;
      logic        timer;
      logic        ack;
      logic [31:0] badv;
      logic [31:0] eentry;
      logic [31:0] era;
      logic [31:0] pc;
   } stim_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               valid_e, ale_e, illinst_e, ertn_e, timer_intr;
   logic [GRLEN-1:0]   pc_e, badv_e, csr_eentry, csr_era;
   logic               exu_ifu_except, ecl_csr_ale_e, ecl_csr_illinst_e, ecl_csr_ertn_e, kill_e;
   logic [GRLEN-1:0]   lsu_csr_badv_e;
   logic [ECODE_W-1:0] ecode;
   logic [1:0]         dbg_state;

   cpu7_exu_excp_ctl_if #(.GRLEN(GRLEN)) redir_if ();

   cpu7_exu_excp_ctl #(.GRLEN(GRLEN), .DRAIN_CYC(DRAIN_CYC), .ECODE_W(ECODE_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .valid_e           (valid_e),
      .pc_e              (pc_e),
      .ale_e             (ale_e),
      .badv_e            (badv_e),
      .illinst_e         (illinst_e),
      .ertn_e            (ertn_e),
      .timer_intr        (timer_intr),
      .csr_eentry        (csr_eentry),
      .csr_era           (csr_era),
      .exu_ifu_except    (exu_ifu_except),
      .ecl_csr_ale_e     (ecl_csr_ale_e),
      .ecl_csr_illinst_e (ecl_csr_illinst_e),
      .ecl_csr_ertn_e    (ecl_csr_ertn_e),
      .lsu_csr_badv_e    (lsu_csr_badv_e),
      .kill_e            (kill_e),
      .ecode             (ecode),
      .dbg_state         (dbg_state),
      .redir             (redir_if.master)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A redirect is "pending" from the event edge until the ack edge; after the
   // ack the stage stays squashed through cycle (ack_cycle + DRAIN_CYC).
   logic [W-1:0]       exp_q[$];
   bit                 m_pending  = 1'b0;
   int                 m_drain_end = -1;
   logic [31:0]        m_rpc      = '0;
   logic [5:0]         m_ecode    = '0;
   int                 cyc        = 0;
   bit                 stim_done  = 1'b0;

   task automatic drive(input stim_t s);
      bit acc, ev, rt, e_ill, e_ale, kill, vld;
      @(posedge clk);
      #1;
      rst                       = s.rst;
      valid_e                   = s.valid;
      ale_e                     = s.ale;
      illinst_e                 = s.ill;
      ertn_e                    = s.ertn;
      timer_intr                = s.timer;
      redir_if.ifu_redirect_ack = s.ack;
      badv_e                    = s.badv;
      csr_eentry                = s.eentry;
      csr_era                   = s.era;
      pc_e                      = s.pc;

      acc   = s.rst || (!m_pending && cyc > m_drain_end);
      ev    = acc && s.valid && (s.timer || s.ill || s.ale);
      rt    = acc && s.valid && s.ertn && !ev;
      e_ill = ev && !s.timer && s.ill;
      e_ale = ev && !s.timer && !s.ill && s.ale;
      kill  = ev || !acc;
      vld   = m_pending;
      exp_q.push_back({ev, e_ale, e_ill, rt, kill, vld, s.badv, m_rpc, m_ecode});

      if (s.rst) begin
         m_pending   = 1'b0;
         m_drain_end = -1;
         m_rpc       = '0;
         m_ecode     = '0;
      end else if (ev || rt) begin
         m_pending = 1'b1;
         m_rpc     = ev ? s.eentry : s.era;
         if (ev) m_ecode = s.timer ? 6'h00 : (s.ill ? 6'h0D : 6'h09);
      end else if (m_pending && s.ack) begin
         m_pending   = 1'b0;
         m_drain_end = cyc + DRAIN_CYC;
      end
      cyc++;
   endtask

   function automatic stim_t base();
      stim_t s;
      s        = '0;
      s.badv   = $urandom;
      s.eentry = $urandom;
      s.era    = $urandom;
      s.pc     = $urandom;
      return s;
   endfunction

   task automatic finish_redir();
      stim_t s;
      s     = base();
      s.ack = 1'b1;
      drive(s);
      repeat (DRAIN_CYC) drive(base());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      stim_t s;
      rst = 1'b1; valid_e = 0; ale_e = 0; illinst_e = 0; ertn_e = 0; timer_intr = 0;
      redir_if.ifu_redirect_ack = 0;
      pc_e = '0; badv_e = '0; csr_eentry = '0; csr_era = '0;
      repeat (2) @(posedge clk);

      s = base(); s.rst = 1'b1;
      drive(s); drive(s);

      // illegal instruction, then ack held low with new illinst ignored
      s = base(); s.valid = 1; s.ill = 1; s.pc = 32'h1c000040; s.eentry = 32'h1c008000;
      drive(s);
      repeat (5) begin
         s = base(); s.valid = 1; s.ill = 1;
         drive(s);
      end
      s = base(); s.ack = 1;
      drive(s);
      repeat (DRAIN_CYC) begin
         s = base(); s.valid = 1; s.ill = 1;
         drive(s);
      end
      // first accepting cycle after drain: misaligned access
      s = base(); s.valid = 1; s.ale = 1; s.badv = 32'h1003;
      drive(s);
      finish_redir();

      // ale loses to timer
      s = base(); s.valid = 1; s.ale = 1; s.timer = 1; s.badv = 32'h1003;
      drive(s);
      finish_redir();

      // ertn
      s = base(); s.valid = 1; s.ertn = 1; s.era = 32'h1c000044;
      drive(s);
      finish_redir();

      // ertn loses to illinst
      s = base(); s.valid = 1; s.ertn = 1; s.ill = 1;
      drive(s);
      finish_redir();

      // reset in REDIR, then illinst right after reset
      s = base(); s.valid = 1; s.ill = 1;
      drive(s);
      drive(base());
      s = base(); s.rst = 1;
      drive(s);
      s = base(); s.valid = 1; s.ill = 1; s.eentry = 32'h1c008000;
      drive(s);
      finish_redir();

      // timer held with no valid instruction, then a single pulse
      repeat (4) begin
         s = base(); s.timer = 1;
         drive(s);
      end
      s = base(); s.timer = 1; s.valid = 1;
      drive(s);
      s = base(); s.timer = 1; s.valid = 1;
      drive(s);
      finish_redir();

      // random traffic
      repeat (2000) begin
         s       = base();
         s.valid = ($urandom_range(0, 3) != 0);
         s.timer = ($urandom_range(0, 7) == 0);
         s.ill   = ($urandom_range(0, 4) == 0);
         s.ale   = ($urandom_range(0, 4) == 0);
         s.ertn  = ($urandom_range(0, 3) == 0);
         s.ack   = ($urandom_range(0, 2) == 0);
         s.rst   = ($urandom_range(0, 99) == 0);
         drive(s);
      end

      @(posedge clk);
      stim_done = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("except",       32'(exu_ifu_except),     32'(e[W-1]));
         chk("csr_ale",      32'(ecl_csr_ale_e),      32'(e[W-2]));
         chk("csr_illinst",  32'(ecl_csr_illinst_e),  32'(e[W-3]));
         chk("csr_ertn",     32'(ecl_csr_ertn_e),     32'(e[W-4]));
         chk("kill_e",       32'(kill_e),             32'(e[W-5]));
         chk("redirect_vld", 32'(redir_if.redirect_vld), 32'(e[W-6]));
         chk("badv",         lsu_csr_badv_e,          e[W-7 -: 32]);
         chk("redirect_pc",  redir_if.redirect_pc,    e[W-39 -: 32]);
         chk("ecode",        32'(ecode),              32'(e[ECODE_W-1:0]));
      end else if (stim_done) begin
         chk("queue_drained", 32'(exp_q.size()), 32'd0);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule
